// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - signal bundle between mem_arbiter, both caches and datamem
//
// Purpose: groups the I-cache, D-cache and datamem handshake signals.
// Ports (signals):
//   i_req/i_addr/i_rdata/i_ready                 - I-cache line read
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ready    - D-cache line fill / write-back
//   mem_req/WriteEnable/memory_address/mem_writedata/mem_readdata/mem_ready - datamem
//   busy                                         - arbiter not idle
// Modports:
//   master - the arbiter (masters datamem, serves both caches)
//   slave  - the environment (caches and datamem)
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_ready;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_ready;

  logic                  mem_req;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [LINE_WIDTH-1:0] mem_writedata;
  logic [LINE_WIDTH-1:0] mem_readdata;
  logic                  mem_ready;

  logic                  busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_readdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready,
    output mem_req, WriteEnable, memory_address, mem_writedata, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_readdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  mem_req, WriteEnable, memory_address, mem_writedata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line arbiter in front of the shared datamem
//
// Purpose: serialises line transactions from the instruction cache (read-only)
// and the data cache (read/write) onto one memory port, one at a time. The
// request is latched at grant. D wins a tie unless it has already taken
// MAX_D_BURST grants in a row while I was waiting, in which case I goes next.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - mem_arbiter_if.master (cache request/response, datamem, busy)
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int MAX_D_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_D_BURST);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e                state_q,   state_d;
  owner_e                owner_q,   owner_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  we_q,      we_d;
  logic [LINE_WIDTH-1:0] wdata_q,   wdata_d;
  logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]      burst_q,   burst_d;

  logic pick_d;
  logic pick_i;

  // D is refused only when I is waiting and D has used up its burst allowance.
  assign pick_d = bus.d_req && (!bus.i_req || (burst_q != BURST_MAX));
  assign pick_i = bus.i_req && !pick_d;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    burst_d   = burst_q;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = BUSY;
          owner_d = OWN_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          // Only grants that overtake a waiting I count toward the burst.
          if (!bus.i_req) begin
            burst_d = '0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + CNT_W'(1);
          end
        end else if (pick_i) begin
          state_d = BUSY;
          owner_d = OWN_I;
          addr_d  = bus.i_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          burst_d = '0;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = bus.mem_readdata;
            end else begin
              i_rdata_d = bus.mem_readdata;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      burst_q   <= burst_d;
    end
  end

  assign bus.mem_req        = (state_q == BUSY);
  assign bus.WriteEnable    = (state_q == BUSY) && we_q;
  assign bus.memory_address = addr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.i_rdata        = i_rdata_q;
  assign bus.d_rdata        = d_rdata_q;
  assign bus.i_ready        = (state_q == RESP) && (owner_q == OWN_I);
  assign bus.d_ready        = (state_q == RESP) && (owner_q == OWN_D);
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int LW   = 128;
  localparam int MAXB = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [LW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_D_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory contents seen by the responder, and the reference copy used by the model
  logic [LW-1:0] mem_model [logic [AW-1:0]];
  logic [LW-1:0] ref_mem   [logic [AW-1:0]];

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  function automatic logic [LW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- datamem responder ----------------
  bit   resp_en  = 1'b1;
  bit   lat_rand = 1'b0;
  int   lat      = 2;
  bit   inject   = 1'b0;
  bit   pending  = 1'b0;
  int   rcnt     = 0;
  txn_t cap;
  txn_t mem_log[$];
  int   stab_err = 0;
  int   fire_cyc = -10;
  int   first_req_cyc = -1;

  initial begin
    bus.mem_ready    = 1'b0;
    bus.mem_readdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (inject) begin
        bus.mem_ready    = 1'b1;
        bus.mem_readdata = rnd_line();
        inject           = 1'b0;
      end else if (!rst || !resp_en) begin
        pending = 1'b0;
      end else if (bus.mem_req === 1'b1) begin
        if (!pending) begin
          pending       = 1'b1;
          cap.addr      = bus.memory_address;
          cap.we        = bus.WriteEnable;
          cap.wdata     = bus.mem_writedata;
          mem_log.push_back(cap);
          first_req_cyc = cyc;
          rcnt          = lat_rand ? int'($urandom_range(1, 4)) - 1 : lat - 1;
        end else if (bus.memory_address !== cap.addr || bus.WriteEnable !== cap.we ||
                     bus.mem_writedata !== cap.wdata) begin
          stab_err++;
        end
        if (rcnt == 0) begin
          bus.mem_ready = 1'b1;
          if (cap.we) begin
            mem_model[cap.addr] = cap.wdata;
            bus.mem_readdata    = rnd_line();
          end else begin
            bus.mem_readdata = mem_model.exists(cap.addr) ? mem_model[cap.addr] : dflt(cap.addr);
          end
          fire_cyc = cyc;
          pending  = 1'b0;
        end else begin
          rcnt--;
        end
      end
    end
  end

  // ---------------- ready monitor ----------------
  int i_pulses = 0;
  int d_pulses = 0;
  int overlap  = 0;
  always @(negedge clk) begin
    if (bus.i_ready === 1'b1) i_pulses++;
    if (bus.d_ready === 1'b1) d_pulses++;
    if (bus.i_ready === 1'b1 && bus.d_ready === 1'b1) overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- traffic and reference model ----------------
  txn_t          iq[$], dq[$], exp_order[$];
  logic [LW-1:0] exp_ir[$], exp_dr[$], obs_ir[$], obs_dr[$];
  logic [LW-1:0] last_i = '0;
  logic [LW-1:0] last_d = '0;
  int timeouts   = 0;
  int lat_bad    = 0;
  int d_done     = 0;
  int i_first_d  = -1;

  // Both requesters re-request immediately, so at every decision each one is
  // waiting exactly when it still has work left.
  task automatic build_model();
    int ii = 0;
    int di = 0;
    int cnt = 0;
    bit i_wait;
    exp_order.delete(); exp_ir.delete(); exp_dr.delete();
    while (ii < iq.size() || di < dq.size()) begin
      i_wait = (ii < iq.size());
      if (di < dq.size() && (!i_wait || cnt < MAXB)) begin
        exp_order.push_back(dq[di]);
        if (dq[di].we) ref_mem[dq[di].addr] = dq[di].wdata;
        else last_d = ref_rd(dq[di].addr);
        exp_dr.push_back(last_d);
        cnt = i_wait ? cnt + 1 : 0;
        di++;
      end else begin
        exp_order.push_back(iq[ii]);
        last_i = ref_rd(iq[ii].addr);
        exp_ir.push_back(last_i);
        cnt = 0;
        ii++;
      end
    end
  endtask

  task automatic drive_i();
    for (int k = 0; k < iq.size(); k++) begin
      int w = 0;
      bus.i_req  = 1'b1;
      bus.i_addr = iq[k].addr;
      do begin @(negedge clk); w++; end while (bus.i_ready !== 1'b1 && w < 400);
      if (bus.i_ready !== 1'b1) begin timeouts++; break; end
      obs_ir.push_back(bus.i_rdata);
      if (cyc != fire_cyc + 1) lat_bad++;
      if (i_first_d < 0) i_first_d = d_done;
    end
    bus.i_req  = 1'b0;
    bus.i_addr = $urandom;
  endtask

  task automatic drive_d();
    for (int k = 0; k < dq.size(); k++) begin
      int w = 0;
      bus.d_req   = 1'b1;
      bus.d_we    = dq[k].we;
      bus.d_addr  = dq[k].addr;
      bus.d_wdata = dq[k].wdata;
      do begin @(negedge clk); w++; end while (bus.d_ready !== 1'b1 && w < 400);
      if (bus.d_ready !== 1'b1) begin timeouts++; break; end
      obs_dr.push_back(bus.d_rdata);
      if (cyc != fire_cyc + 1) lat_bad++;
      d_done++;
    end
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
  endtask

  task automatic run_traffic();
    build_model();
    mem_log.delete(); obs_ir.delete(); obs_dr.delete();
    timeouts = 0; lat_bad = 0; stab_err = 0; d_done = 0; i_first_d = -1;
    i_pulses = 0; d_pulses = 0; overlap = 0;
    fork
      drive_i();
      drive_d();
    join
    repeat (2) @(negedge clk);
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input logic we, input logic [LW-1:0] wd);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd;
    return t;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.WriteEnable, bus.i_ready, bus.d_ready, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.mem_req, bus.WriteEnable, bus.i_ready, bus.d_ready, bus.busy});
    end
    checks++;
    if ({bus.memory_address, bus.mem_writedata, bus.i_rdata, bus.d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wd=%h ir=%h dr=%h expected all zero",
               bus.memory_address, bus.mem_writedata, bus.i_rdata, bus.d_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single_i_read();
    int start;
    logic [LW-1:0] line = 128'hDEADBEEF_01234567_89ABCDEF_00000001;
    mem_model[32'h100] = line;
    ref_mem[32'h100]   = line;
    lat = 3; lat_rand = 1'b0;
    iq.delete(); dq.delete();
    iq.push_back(mk(32'h100, 1'b0, '0));
    start = cyc;
    run_traffic();
    checks++;
    if (timeouts !== 0) begin errors++; $display("FAIL single_timeout: got %0d expected 0", timeouts); end
    checks++;
    if (mem_log.size() !== 1) begin errors++; $display("FAIL single_txn_count: got %0d expected 1", mem_log.size()); end
    else begin
      checks++;
      if (mem_log[0].addr !== 32'h100 || mem_log[0].we !== 1'b0) begin
        errors++; $display("FAIL single_addr_we: got %h/%b expected 00000100/0", mem_log[0].addr, mem_log[0].we);
      end
    end
    checks++;
    if (first_req_cyc !== start + 1) begin
      errors++; $display("FAIL single_req_latency: got cycle %0d expected %0d", first_req_cyc, start + 1);
    end
    checks++;
    if (obs_ir.size() !== 1 || obs_ir[0] !== line) begin
      errors++; $display("FAIL single_rdata: got %h expected %h", obs_ir.size() ? obs_ir[0] : '0, line);
    end
    checks++;
    if (lat_bad !== 0) begin errors++; $display("FAIL single_ready_latency: got %0d late pulses expected 0", lat_bad); end
    checks++;
    if (i_pulses !== 1 || d_pulses !== 0) begin
      errors++; $display("FAIL single_pulses: got i=%0d d=%0d expected i=1 d=0", i_pulses, d_pulses);
    end
  endtask

  task automatic test_d_writeback();
    logic [LW-1:0] ones = {LW{1'b1}} / 15;
    lat = 4; lat_rand = 1'b0;
    iq.delete(); dq.delete();
    dq.push_back(mk(32'h200, 1'b1, ones));
    run_traffic();
    checks++;
    if (mem_log.size() !== 1) begin errors++; $display("FAIL wb_txn_count: got %0d expected 1", mem_log.size()); end
    else begin
      checks++;
      if (mem_log[0].addr !== 32'h200 || mem_log[0].we !== 1'b1 || mem_log[0].wdata !== ones) begin
        errors++; $display("FAIL wb_txn: got %h/%b/%h expected 00000200/1/%h",
                           mem_log[0].addr, mem_log[0].we, mem_log[0].wdata, ones);
      end
    end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL wb_stable: got %0d changes expected 0", stab_err); end
    checks++;
    if (obs_dr.size() !== 1 || obs_dr[0] !== exp_dr[0]) begin
      errors++; $display("FAIL wb_rdata_unchanged: got %h expected %h", obs_dr.size() ? obs_dr[0] : '0, exp_dr[0]);
    end
    checks++;
    if (d_pulses !== 1 || i_pulses !== 0) begin
      errors++; $display("FAIL wb_pulses: got d=%0d i=%0d expected d=1 i=0", d_pulses, i_pulses);
    end
  endtask

  task automatic test_simultaneous();
    lat_rand = 1'b1;
    iq.delete(); dq.delete();
    iq.push_back(mk(32'h500, 1'b0, '0));
    dq.push_back(mk(32'h600, 1'b0, rnd_line()));
    run_traffic();
    checks++;
    if (mem_log.size() !== 2) begin errors++; $display("FAIL sim_txn_count: got %0d expected 2", mem_log.size()); end
    else begin
      checks++;
      if (mem_log[0].addr !== 32'h600 || mem_log[1].addr !== 32'h500) begin
        errors++; $display("FAIL sim_order: got %h,%h expected 00000600,00000500", mem_log[0].addr, mem_log[1].addr);
      end
    end
    checks++;
    if (obs_ir.size() !== 1 || obs_dr.size() !== 1 || obs_ir[0] !== exp_ir[0] || obs_dr[0] !== exp_dr[0]) begin
      errors++; $display("FAIL sim_rdata: got i=%h d=%h expected i=%h d=%h",
                         obs_ir.size() ? obs_ir[0] : '0, obs_dr.size() ? obs_dr[0] : '0, exp_ir[0], exp_dr[0]);
    end
    checks++;
    if (overlap !== 0 || lat_bad !== 0) begin
      errors++; $display("FAIL sim_ready_rules: got overlap=%0d late=%0d expected 0/0", overlap, lat_bad);
    end
  endtask

  task automatic test_starvation();
    lat_rand = 1'b1;
    iq.delete(); dq.delete();
    for (int k = 0; k < 2; k++) iq.push_back(mk(32'h7000 + 32'(k * 16), 1'b0, '0));
    for (int k = 0; k < 6; k++) dq.push_back(mk(32'h8000 + 32'(k * 16), k[0], rnd_line()));
    run_traffic();
    checks++;
    if (i_first_d !== MAXB) begin
      errors++; $display("FAIL starve_first_i: got after %0d d_ready expected %0d", i_first_d, MAXB);
    end
    checks++;
    if (mem_log.size() !== exp_order.size()) begin
      errors++; $display("FAIL starve_txn_count: got %0d expected %0d", mem_log.size(), exp_order.size());
    end
    for (int k = 0; k < mem_log.size() && k < exp_order.size(); k++) begin
      checks++;
      if (mem_log[k].addr !== exp_order[k].addr || mem_log[k].we !== exp_order[k].we) begin
        errors++; $display("FAIL starve_order[%0d]: got %h/%b expected %h/%b",
                           k, mem_log[k].addr, mem_log[k].we, exp_order[k].addr, exp_order[k].we);
      end
    end
    checks++;
    if (timeouts !== 0 || overlap !== 0) begin
      errors++; $display("FAIL starve_health: got timeouts=%0d overlap=%0d expected 0/0", timeouts, overlap);
    end
  endtask

  task automatic test_input_change();
    int w = 0;
    logic [LW-1:0] exp_line;
    lat = 4; lat_rand = 1'b0;
    mem_log.delete(); stab_err = 0; d_pulses = 0; i_pulses = 0;
    exp_line = ref_rd(32'h300);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300; bus.d_wdata = rnd_line();
    @(negedge clk);
    bus.d_addr = 32'h400; bus.d_we = 1'b1; bus.d_wdata = rnd_line();
    do begin @(negedge clk); w++; end while (bus.d_ready !== 1'b1 && w < 50);
    checks++;
    if (bus.d_ready !== 1'b1) begin errors++; $display("FAIL chg_timeout: got no d_ready expected d_ready"); end
    checks++;
    if (bus.d_rdata !== exp_line) begin errors++; $display("FAIL chg_rdata: got %h expected %h", bus.d_rdata, exp_line); end
    last_d = exp_line;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_log.size() !== 1 || mem_log[0].addr !== 32'h300 || mem_log[0].we !== 1'b0) begin
      errors++; $display("FAIL chg_latched: got n=%0d addr=%h expected n=1 addr=00000300",
                         mem_log.size(), mem_log.size() ? mem_log[0].addr : '0);
    end
    checks++;
    if (stab_err !== 0) begin errors++; $display("FAIL chg_stable: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    resp_en = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h900;
    do begin @(negedge clk); w++; end while (bus.mem_req !== 1'b1 && w < 20);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.busy, bus.i_ready, bus.d_ready} !== 4'b0) begin
      errors++; $display("FAIL rstmid_async: got req/busy/ir/dr=%b expected 0000",
                         {bus.mem_req, bus.busy, bus.i_ready, bus.d_ready});
    end
    checks++;
    if (bus.memory_address !== '0) begin
      errors++; $display("FAIL rstmid_addr: got %h expected 0", bus.memory_address);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    i_pulses = 0; d_pulses = 0;
    inject = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || i_pulses !== 0 || d_pulses !== 0) begin
      errors++; $display("FAIL rstmid_ignore_ready: got busy=%b i=%0d d=%0d expected 0/0/0",
                         bus.busy, i_pulses, d_pulses);
    end
    resp_en = 1'b1; lat_rand = 1'b1;
    last_i = '0; last_d = '0;
    iq.delete(); dq.delete();
    iq.push_back(mk(32'hA00, 1'b0, '0));
    run_traffic();
    checks++;
    if (mem_log.size() !== 1 || obs_ir.size() !== 1 || obs_ir[0] !== exp_ir[0]) begin
      errors++; $display("FAIL rstmid_regrant: got n=%0d rdata=%h expected n=1 rdata=%h",
                         mem_log.size(), obs_ir.size() ? obs_ir[0] : '0, exp_ir[0]);
    end
  endtask

  task automatic test_random();
    lat_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int ni = int'($urandom_range(0, 5));
      int nd = int'($urandom_range(1, 8));
      iq.delete(); dq.delete();
      for (int k = 0; k < ni; k++) iq.push_back(mk(32'hB000 + 32'($urandom_range(0, 7) * 16), 1'b0, '0));
      for (int k = 0; k < nd; k++)
        dq.push_back(mk(32'hB000 + 32'($urandom_range(0, 7) * 16), 1'($urandom_range(0, 1)), rnd_line()));
      run_traffic();
      checks++;
      if (mem_log.size() !== exp_order.size() || timeouts !== 0) begin
        errors++; $display("FAIL rnd%0d_count: got %0d txns timeouts=%0d expected %0d txns",
                           r, mem_log.size(), timeouts, exp_order.size());
      end
      for (int k = 0; k < mem_log.size() && k < exp_order.size(); k++) begin
        checks++;
        if (mem_log[k].addr !== exp_order[k].addr || mem_log[k].we !== exp_order[k].we ||
            (exp_order[k].we && mem_log[k].wdata !== exp_order[k].wdata)) begin
          errors++; $display("FAIL rnd%0d_txn[%0d]: got %h/%b expected %h/%b",
                             r, k, mem_log[k].addr, mem_log[k].we, exp_order[k].addr, exp_order[k].we);
        end
      end
      for (int k = 0; k < obs_ir.size() && k < exp_ir.size(); k++) begin
        checks++;
        if (obs_ir[k] !== exp_ir[k]) begin
          errors++; $display("FAIL rnd%0d_i_rdata[%0d]: got %h expected %h", r, k, obs_ir[k], exp_ir[k]);
        end
      end
      for (int k = 0; k < obs_dr.size() && k < exp_dr.size(); k++) begin
        checks++;
        if (obs_dr[k] !== exp_dr[k]) begin
          errors++; $display("FAIL rnd%0d_d_rdata[%0d]: got %h expected %h", r, k, obs_dr[k], exp_dr[k]);
        end
      end
      checks++;
      if (overlap !== 0 || stab_err !== 0 || lat_bad !== 0 || i_pulses !== ni || d_pulses !== nd) begin
        errors++; $display("FAIL rnd%0d_rules: got ovl=%0d stab=%0d late=%0d i=%0d d=%0d expected 0/0/0/%0d/%0d",
                           r, overlap, stab_err, lat_bad, i_pulses, d_pulses, ni, nd);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_simultaneous();
    test_starvation();
    test_input_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing line memory (`datamem`, 128-bit line interface) between the instruction cache (port I, read-only) and the data cache (port D, read/write).
- Sits between both caches and `datamem`.
- Sequences one line transaction at a time and latches the request at grant.
- D has priority, bounded by a starvation guard so instruction fetch always makes progress.

Parameters:
- ADDR_WIDTH, 32, byte address width of line requests.
- LINE_WIDTH, 128, cache line / memory data width.
- MAX_D_BURST, 4, consecutive D grants allowed while I is waiting before I is forced a grant (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_req  input  1  I-cache line-read request, level, held until i_ready.
- i_addr  input  ADDR_WIDTH  I-cache line address.
- i_rdata  output  LINE_WIDTH  line returned to I-cache, valid while i_ready=1.
- i_ready  output  1  one-cycle completion pulse to I-cache.
- d_req  input  1  D-cache line request, level, held until d_ready.
- d_we  input  1  1 = line write-back, 0 = line fill.
- d_addr  input  ADDR_WIDTH  D-cache line address.
- d_wdata  input  LINE_WIDTH  write-back line.
- d_rdata  output  LINE_WIDTH  line returned to D-cache, valid while d_ready=1.
- d_ready  output  1  one-cycle completion pulse to D-cache.
- mem_req  output  1  request to `datamem`, held until mem_ready.
- WriteEnable  output  1  write qualifier to `datamem`.
- memory_address  output  ADDR_WIDTH  address to `datamem`.
- mem_writedata  output  LINE_WIDTH  write line to `datamem`.
- mem_readdata  input  LINE_WIDTH  read line from `datamem`, valid with mem_ready.
- mem_ready  input  1  `datamem` completion pulse.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, also mid-transaction):
  - state=IDLE, burst counter=0.
  - mem_req, WriteEnable, i_ready, d_ready, busy = 0.
  - memory_address, mem_writedata, i_rdata, d_rdata = 0.
  - An in-flight memory transaction is abandoned; requesters must re-request.
- States: IDLE, BUSY (owner ∈ {I,D}), RESP (owner kept).
- IDLE grant decision:
  - D only → grant D.
  - I only → grant I.
  - Both → grant D, unless burst counter == MAX_D_BURST, in which case grant I.
  - Neither → stay in IDLE.
- On grant (edge out of IDLE):
  - Latch address, we, wdata into internal registers. For I, we=0 and wdata=0.
  - Go to BUSY. Requester inputs are don't-care after the grant edge until ready.
- BUSY:
  - mem_req=1, with WriteEnable, memory_address, mem_writedata driven from the latched registers and stable.
  - Stay until mem_ready=1.
  - On the mem_ready edge: if it was a read, register mem_readdata into the owner's rdata register; go to RESP.
- RESP (exactly one cycle):
  - Owner's ready=1, mem_req=0; then go to IDLE.
  - For a D write, d_ready pulses and d_rdata is unchanged.
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req high at cycle 1.
  - mem_ready at cycle k → ready at cycle k+1 → IDLE at cycle k+2.
  - Minimum request-to-ready is 2 cycles plus memory latency.
- Requester rule: req is deasserted on the edge at which ready was seen. IDLE always lasts ≥1 cycle between transactions, so a stale req is never re-granted.
- Burst counter:
  - Increments (saturating at MAX_D_BURST) on each D grant made while i_req=1.
  - Clears to 0 on any I grant.
  - Clears to 0 on any D grant made while i_req=0.
- Ignored events:
  - mem_ready in IDLE or RESP is ignored.
  - Requests arriving while BUSY/RESP wait; the requester holds req.
- Non-owner ready is always 0. i_ready and d_ready are never high in the same cycle.
- The non-owner's rdata holds its last value.
- busy=1 in BUSY and RESP.

Test Plan:
- Single I read:
  - Stimulus: i_req=1, i_addr=0x0000_0100; memory returns mem_ready 3 cycles after mem_req with mem_readdata=0xDEADBEEF_…_01.
  - Required: memory_address=0x100 and WriteEnable=0 while mem_req=1; i_ready pulses once the cycle after mem_ready with i_rdata equal to that line; d_ready stays 0.
- D write-back:
  - Stimulus: d_req=1, d_we=1, d_addr=0x200, d_wdata=0x1111…1111.
  - Required: WriteEnable=1 and mem_writedata=0x1111…1111 held stable until mem_ready; d_ready pulses once; d_rdata unchanged.
- Simultaneous requests:
  - Stimulus: i_req and d_req rise in the same cycle.
  - Required: D served first; I granted in the IDLE cycle after d_ready; exactly two mem_req transactions, in D then I address order.
- Starvation guard:
  - Stimulus: MAX_D_BURST=4; d_req re-asserted immediately after every d_ready while i_req is held high.
  - Required: grant order D,D,D,D,I,D…; i_ready occurs after the 4th d_ready.
- Input change after grant:
  - Stimulus: d_addr changes from 0x300 to 0x400 one cycle after the grant.
  - Required: memory_address stays 0x300 for the whole transaction.
- Reset mid-transaction:
  - Stimulus: rst driven low while in BUSY.
  - Required: mem_req, busy, i_ready, d_ready go to 0 immediately (without a clock edge); a subsequent mem_ready is ignored; after rst returns to 1, a fresh i_req is granted normally.
